impact_access_sequencer: RTL and testbench
==========================================

IMPACT_ACCESS_SEQUENCER -- requirements
Module: impact_access_sequencer

Interface
REQ-001 The block SHALL have parameter PRE_CYCLES, default 2: number of precharge cycles per access, legal range 1..15.
REQ-002 The block SHALL have parameter ACC_CYCLES, default 3: number of read/write strobe cycles per access, legal range 1..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: an access request is present.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the sequencer accepts a request this cycle.
REQ-007 The block SHALL have port req_write, input, 1 bit: 1 = write, 0 = read.
REQ-008 The block SHALL have ports req_proj_sel and req_byte_sel, inputs, 2 bits each: project select and byte select for the access.
REQ-009 The block SHALL have ports req_byte_mode and req_trunc, inputs, 1 bit each: byte-mode and truncation enables.
REQ-010 The block SHALL have port req_wdata, input, 8 bits: write data.
REQ-011 The block SHALL have ports rsp_valid (output, 1 bit), rsp_write (output, 1 bit) and rsp_rdata (output, 8 bits): access-complete pulse, its type, and the captured read data.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every non-IDLE state.
REQ-013 The block SHALL have macro-side outputs of 1 bit each: PreCharge, WL_enable, ReadEnable, WriteEnable, Data_In_Enable, Byte_Mode_Enable and Trunc_Enable.
REQ-014 The block SHALL have macro-side outputs Proj_Select (2 bits), Byte_Select (2 bits) and Data_In (8 bits).
REQ-015 The block SHALL have macro-side input Data_Out, 8 bits, carrying macro read data.

Function
REQ-016 The FSM SHALL have the states IDLE, PRECHARGE, WLSETUP, ACCESS and RECOVER.
REQ-017 req_ready SHALL be 1 only in IDLE while rst = 0; a request is accepted on a clock edge where req_valid and req_ready are both 1.
REQ-018 On accept, the block SHALL register req_write, proj_sel, byte_sel, byte_mode, trunc and wdata onto Proj_Select, Byte_Select, Byte_Mode_Enable, Trunc_Enable and Data_In, and hold them unchanged until the next accept.
REQ-019 Transitions SHALL be: IDLE->PRECHARGE on accept; PRECHARGE->WLSETUP after PRE_CYCLES cycles; WLSETUP->ACCESS after 1 cycle; ACCESS->RECOVER after ACC_CYCLES cycles; RECOVER->IDLE after 1 cycle.
REQ-020 A single 4-bit down-counter SHALL time PRECHARGE and ACCESS; it is loaded with N-1 on state entry and the state is left when the counter equals 0.
REQ-021 PreCharge SHALL be 1 exactly in PRECHARGE.
REQ-022 WL_enable SHALL be 1 exactly in WLSETUP and ACCESS.
REQ-023 ReadEnable SHALL be 1 in ACCESS for a read only; WriteEnable and Data_In_Enable SHALL be 1 in ACCESS for a write only.
REQ-024 Invariants: PreCharge & WL_enable = 0 always; ReadEnable & WriteEnable = 0 always; all strobes are 0 in IDLE and RECOVER.
REQ-025 Read capture: on the edge leaving the last ACCESS cycle, the block SHALL register Data_Out into rsp_rdata.
REQ-026 For a write, rsp_rdata SHALL keep its previous value.
REQ-027 rsp_valid SHALL be a 1-cycle pulse during RECOVER, with rsp_write equal to the latched req_write; there is no backpressure.
REQ-028 Latency: with the accept edge at cycle 0, rsp_valid is high in cycle PRE_CYCLES+ACC_CYCLES+2, and the earliest next accept is the following cycle.
REQ-029 A req_valid that is high while busy = 1 SHALL be ignored (not queued); the requester holds it until req_ready.
REQ-030 Changes on the req_* inputs after accept SHALL have no effect on the access in progress.
REQ-031 Counter loads SHALL be computed in 4 bits; values outside 1..15 are illegal, the RTL asserts on them in simulation, and behaviour for them is undefined.

Reset
REQ-032 When rst = 1 at a clock edge, the state SHALL become IDLE at that edge, in any state including mid-access.
REQ-033 On reset, every output SHALL be 0 except req_ready: PreCharge, WL_enable, ReadEnable, WriteEnable, Data_In_Enable, Byte_Mode_Enable, Trunc_Enable, Proj_Select, Byte_Select, Data_In, rsp_valid, rsp_write, rsp_rdata and busy; the counter also resets to 0.
REQ-034 req_ready SHALL be 0 while rst = 1 and SHALL be 1 in the first cycle after rst deasserts.
REQ-035 An access aborted by reset SHALL produce no rsp_valid.

Verification
REQ-036 Default-parameter read: proj=2, byte_sel=1, Data_Out=0xA5 accepted at cycle 0 -> PreCharge high in cycles 1-2, WL_enable high in 3-6, ReadEnable high in 4-6, rsp_valid=1 with rsp_rdata=0xA5 in cycle 7, req_ready=1 in cycle 8.
REQ-037 Default-parameter write: wdata=0x3C -> WriteEnable and Data_In_Enable high in cycles 4-6 with Data_In=0x3C, ReadEnable stays 0, rsp_valid=1 with rsp_write=1 in cycle 7, rsp_rdata unchanged.
REQ-038 Back-to-back: req_valid held high for two requests -> second accept in cycle 8, and no cycle shows PreCharge and WL_enable both high.
REQ-039 Input change after accept: req_wdata and req_proj_sel changed at cycle 2 of a write -> Data_In and Proj_Select keep the accepted values.
REQ-040 Reset mid-access: rst=1 in cycle 5 of a read -> all strobes 0 in cycle 6, no rsp_valid, req_ready=1 in the first cycle after rst drops.
REQ-041 PRE_CYCLES=1, ACC_CYCLES=1 read -> PreCharge in cycle 1, ReadEnable in cycle 3, rsp_valid in cycle 4.

Source files
------------

// File: rtl/impact_access_sequencer_if.sv
// Request/response bus between a requester and the impact access sequencer.
// The requester drives the master modport; the sequencer uses the slave modport.
interface impact_access_sequencer_if;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned DATA_W = 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [SEL_W-1:0]  req_proj_sel;
    logic [SEL_W-1:0]  req_byte_sel;
    logic              req_byte_mode;
    logic              req_trunc;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_proj_sel, req_byte_sel,
               req_byte_mode, req_trunc, req_wdata,
        input  req_ready, rsp_valid, rsp_write, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_proj_sel, req_byte_sel,
               req_byte_mode, req_trunc, req_wdata,
        output req_ready, rsp_valid, rsp_write, rsp_rdata
    );
endinterface

// File: rtl/impact_access_sequencer.sv
// Sequences one memory-macro access: precharge, wordline setup, strobe, recover.
// All macro-side strobes are registered together with the state they belong to.
module impact_access_sequencer #(
    parameter int unsigned PRE_CYCLES = 2,
    parameter int unsigned ACC_CYCLES = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    impact_access_sequencer_if.slave    bus,
    output logic                        busy,
    output logic                        PreCharge,
    output logic                        WL_enable,
    output logic                        ReadEnable,
    output logic                        WriteEnable,
    output logic                        Data_In_Enable,
    output logic                        Byte_Mode_Enable,
    output logic                        Trunc_Enable,
    output logic [1:0]                  Proj_Select,
    output logic [1:0]                  Byte_Select,
    output logic [7:0]                  Data_In,
    input  logic [7:0]                  Data_Out
);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned DATA_W = 8;
    localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACC_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRECHARGE,
        S_WLSETUP,
        S_ACCESS,
        S_RECOVER
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_write;
    logic [SEL_W-1:0]    r_proj_sel;
    logic [SEL_W-1:0]    r_byte_sel;
    logic                r_byte_mode;
    logic                r_trunc;
    logic [DATA_W-1:0]   r_data_in;
    logic                r_precharge;
    logic                r_wl_enable;
    logic                r_read_en;
    logic                r_write_en;
    logic                r_din_en;
    logic                r_busy;
    logic                r_rsp_valid;
    logic                r_rsp_write;
    logic [DATA_W-1:0]   r_rsp_rdata;

    logic                w_req_ready;
    logic                w_accept;

    // Ready is visible in the same cycle reset is released, so it is derived from state and rst.
    assign w_req_ready = (r_state == S_IDLE) && !rst;
    assign w_accept    = bus.req_valid && w_req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_write     <= 1'b0;
            r_proj_sel  <= '0;
            r_byte_sel  <= '0;
            r_byte_mode <= 1'b0;
            r_trunc     <= 1'b0;
            r_data_in   <= '0;
            r_precharge <= 1'b0;
            r_wl_enable <= 1'b0;
            r_read_en   <= 1'b0;
            r_write_en  <= 1'b0;
            r_din_en    <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write     <= bus.req_write;
                        r_proj_sel  <= bus.req_proj_sel;
                        r_byte_sel  <= bus.req_byte_sel;
                        r_byte_mode <= bus.req_byte_mode;
                        r_trunc     <= bus.req_trunc;
                        r_data_in   <= bus.req_wdata;
                        r_cnt       <= PRE_LOAD;
                        r_precharge <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_PRECHARGE;
                    end
                end
                S_PRECHARGE: begin
                    if (r_cnt == '0) begin
                        r_precharge <= 1'b0;
                        r_wl_enable <= 1'b1;
                        r_state     <= S_WLSETUP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_WLSETUP: begin
                    r_cnt      <= ACC_LOAD;
                    r_read_en  <= !r_write;
                    r_write_en <= r_write;
                    r_din_en   <= r_write;
                    r_state    <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (r_cnt == '0) begin
                        r_wl_enable <= 1'b0;
                        r_read_en   <= 1'b0;
                        r_write_en  <= 1'b0;
                        r_din_en    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_write <= r_write;
                        // Read data is sampled at the end of the final strobe cycle.
                        if (!r_write) begin
                            r_rsp_rdata <= Data_Out;
                        end
                        r_state <= S_RECOVER;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_RECOVER: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Simulation guards on parameter range and strobe exclusivity.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (PRE_CYCLES >= 1 && PRE_CYCLES <= 15)
                else $error("PRE_CYCLES outside 1..15");
            assert (ACC_CYCLES >= 1 && ACC_CYCLES <= 15)
                else $error("ACC_CYCLES outside 1..15");
            assert (!(r_precharge && r_wl_enable))
                else $error("PreCharge and WL_enable both high");
            assert (!(r_read_en && r_write_en))
                else $error("ReadEnable and WriteEnable both high");
        end
    end

    assign bus.req_ready    = w_req_ready;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_write    = r_rsp_write;
    assign bus.rsp_rdata    = r_rsp_rdata;
    assign busy             = r_busy;
    assign PreCharge        = r_precharge;
    assign WL_enable        = r_wl_enable;
    assign ReadEnable       = r_read_en;
    assign WriteEnable      = r_write_en;
    assign Data_In_Enable   = r_din_en;
    assign Byte_Mode_Enable = r_byte_mode;
    assign Trunc_Enable     = r_trunc;
    assign Proj_Select      = r_proj_sel;
    assign Byte_Select      = r_byte_sel;
    assign Data_In          = r_data_in;
endmodule

// File: tb/tb_impact_access_sequencer.sv
// Bench for impact_access_sequencer: table of accesses on a default-parameter instance,
// cycle-indexed strobe model, response scoreboard, plus reset-abort and 1/1-cycle sequences.
module tb_impact_access_sequencer;
    localparam int PRE0 = 2;
    localparam int ACC0 = 3;
    localparam int LAT0 = PRE0 + ACC0 + 2;
    localparam int PRE1 = 1;
    localparam int ACC1 = 1;
    localparam int LAT1 = PRE1 + ACC1 + 2;
    localparam int NVEC = 7;

    typedef struct {
        logic       wr;
        logic [1:0] proj;
        logic [1:0] bsel;
        logic       bmode;
        logic       trunc;
        logic [7:0] wdata;
        logic [7:0] dout;
        logic       chg;
        logic       hold;
        logic [7:0] exp_rdata;
    } vec_t;

    typedef struct packed {
        logic       wr;
        logic [7:0] rdata;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] cur_rdata;
    rsp_t sb_q[$];
    vec_t vecs[NVEC];

    impact_access_sequencer_if bus0();
    impact_access_sequencer_if bus1();

    logic       busy0, pc0, wl0, re0, we0, die0, bm0, tr0;
    logic [1:0] ps0, bs0;
    logic [7:0] di0, do0;
    logic       busy1, pc1, wl1, re1, we1, die1, bm1, tr1;
    logic [1:0] ps1, bs1;
    logic [7:0] di1, do1;

    impact_access_sequencer #(.PRE_CYCLES(PRE0), .ACC_CYCLES(ACC0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .busy(busy0),
        .PreCharge(pc0), .WL_enable(wl0), .ReadEnable(re0), .WriteEnable(we0),
        .Data_In_Enable(die0), .Byte_Mode_Enable(bm0), .Trunc_Enable(tr0),
        .Proj_Select(ps0), .Byte_Select(bs0), .Data_In(di0), .Data_Out(do0)
    );

    impact_access_sequencer #(.PRE_CYCLES(PRE1), .ACC_CYCLES(ACC1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .busy(busy1),
        .PreCharge(pc1), .WL_enable(wl1), .ReadEnable(re1), .WriteEnable(we1),
        .Data_In_Enable(die1), .Byte_Mode_Enable(bm1), .Trunc_Enable(tr1),
        .Proj_Select(ps1), .Byte_Select(bs1), .Data_In(di1), .Data_Out(do1)
    );

    always #5 clk = ~clk;

    logic [7:0]  ctl0, ctl1;
    logic [13:0] lat0, lat1;
    assign ctl0 = {pc0, wl0, re0, we0, die0, busy0, bus0.req_ready, bus0.rsp_valid};
    assign ctl1 = {pc1, wl1, re1, we1, die1, busy1, bus1.req_ready, bus1.rsp_valid};
    assign lat0 = {ps0, bs0, bm0, tr0, di0};
    assign lat1 = {ps1, bs1, bm1, tr1, di1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected control pattern in cycle k after the accept edge (k=0 is the accept cycle).
    function automatic logic [7:0] ctl_exp(input int k, input int pre, input int acc, input logic wr);
        logic p, w, a, b, r, v;
        p = (k >= 1) && (k <= pre);
        w = (k >= pre + 1) && (k <= pre + acc + 1);
        a = (k >= pre + 2) && (k <= pre + acc + 1);
        b = (k >= 1) && (k <= pre + acc + 2);
        v = (k == pre + acc + 2);
        r = !b;
        return {p, w, a && !wr, a && wr, a && wr, b, r, v};
    endfunction

    task automatic do_access(input int idx, input vec_t v);
        rsp_t r;
        bus0.req_write     = v.wr;
        bus0.req_proj_sel  = v.proj;
        bus0.req_byte_sel  = v.bsel;
        bus0.req_byte_mode = v.bmode;
        bus0.req_trunc     = v.trunc;
        bus0.req_wdata     = v.wdata;
        bus0.req_valid     = 1'b1;
        do0 = ~v.dout;
        chk($sformatf("ready_c0 v%0d", idx), 32'(bus0.req_ready), 32'd1);
        sb_q.push_back('{wr: v.wr, rdata: v.exp_rdata});
        for (int k = 1; k <= LAT0 + 1; k++) begin
            @(posedge clk);
            #1;
            bus0.req_valid = v.hold;
            if (v.chg && k == 2) begin
                bus0.req_wdata    = ~v.wdata;
                bus0.req_proj_sel = v.proj + 2'd1;
            end
            do0 = (k == PRE0 + ACC0 + 1) ? v.dout : ~v.dout;
            @(negedge clk);
            chk($sformatf("ctl v%0d c%0d", idx, k), 32'(ctl0), 32'(ctl_exp(k, PRE0, ACC0, v.wr)));
            chk($sformatf("latched v%0d c%0d", idx, k), 32'(lat0),
                32'({v.proj, v.bsel, v.bmode, v.trunc, v.wdata}));
            chk($sformatf("pc_wl_excl v%0d c%0d", idx, k), 32'(pc0 & wl0), 32'd0);
            chk($sformatf("re_we_excl v%0d c%0d", idx, k), 32'(re0 & we0), 32'd0);
            if (bus0.rsp_valid) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_empty v%0d c%0d: got rsp_valid=1 expected no response", idx, k);
                end else begin
                    r = sb_q.pop_front();
                    chk($sformatf("rsp_write v%0d", idx), 32'(bus0.rsp_write), 32'(r.wr));
                    chk($sformatf("rsp_rdata v%0d", idx), 32'(bus0.rsp_rdata), 32'(r.rdata));
                end
            end
            if (k == LAT0) cur_rdata = v.exp_rdata;
            chk($sformatf("rdata_hold v%0d c%0d", idx, k), 32'(bus0.rsp_rdata), 32'(cur_rdata));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // wr proj bsel bm tr wdata dout chg hold exp_rdata
        vecs[0] = '{1'b0, 2'd2, 2'd1, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0, 8'hA5};
        vecs[1] = '{1'b1, 2'd1, 2'd3, 1'b1, 1'b0, 8'h3C, 8'h77, 1'b0, 1'b0, 8'hA5};
        vecs[2] = '{1'b1, 2'd0, 2'd2, 1'b0, 1'b1, 8'hC3, 8'h12, 1'b1, 1'b0, 8'hA5};
        vecs[3] = '{1'b0, 2'd3, 2'd0, 1'b1, 1'b1, 8'h81, 8'h5A, 1'b0, 1'b1, 8'h5A};
        vecs[4] = '{1'b0, 2'd1, 2'd2, 1'b0, 1'b1, 8'h42, 8'h0F, 1'b1, 1'b0, 8'h0F};
        vecs[5] = '{1'b1, 2'd2, 2'd1, 1'b1, 1'b0, 8'hFF, 8'hE7, 1'b0, 1'b0, 8'h0F};
        vecs[6] = '{1'b0, 2'd0, 2'd3, 1'b0, 1'b0, 8'h99, 8'h00, 1'b0, 1'b0, 8'h00};

        rst = 1'b1;
        bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_proj_sel = '0;
        bus0.req_byte_sel = '0; bus0.req_byte_mode = 1'b0; bus0.req_trunc = 1'b0;
        bus0.req_wdata = '0;
        bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_proj_sel = '0;
        bus1.req_byte_sel = '0; bus1.req_byte_mode = 1'b0; bus1.req_trunc = 1'b0;
        bus1.req_wdata = '0;
        do0 = 8'h00;
        do1 = 8'h00;
        cur_rdata = 8'h00;

        // Reset state while rst is held, then ready in the first cycle after release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl0", 32'(ctl0), 32'd0);
        chk("rst_lat0", 32'(lat0), 32'd0);
        chk("rst_rsp0", 32'({bus0.rsp_write, bus0.rsp_rdata}), 32'd0);
        chk("rst_ctl1", 32'(ctl1), 32'd0);
        chk("rst_lat1", 32'(lat1), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst0", 32'(bus0.req_ready), 32'd1);
        chk("ready_after_rst1", 32'(bus1.req_ready), 32'd1);

        for (int i = 0; i < NVEC; i++) do_access(i, vecs[i]);

        // Read aborted by reset asserted during cycle 5.
        bus0.req_write = 1'b0;
        bus0.req_proj_sel = 2'd2;
        bus0.req_valid = 1'b1;
        do0 = 8'h99;
        @(posedge clk);
        #1 bus0.req_valid = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            @(posedge clk);
            #1;
            if (k == 5) rst = 1'b1;
        end
        @(negedge clk);
        chk("abort_c5_re", 32'(re0), 32'd1);
        chk("abort_c5_ready", 32'(bus0.req_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        cur_rdata = 8'h00;
        chk("abort_c6_ctl", 32'(ctl0), 32'h02);
        chk("abort_c6_lat", 32'(lat0), 32'd0);
        chk("abort_c6_rdata", 32'(bus0.rsp_rdata), 32'(cur_rdata));
        for (int k = 7; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("abort_norsp c%0d", k), 32'(bus0.rsp_valid), 32'd0);
        end

        // Minimum-length access on the PRE=1/ACC=1 instance.
        bus1.req_write = 1'b0;
        bus1.req_proj_sel = 2'd3;
        bus1.req_byte_sel = 2'd2;
        bus1.req_byte_mode = 1'b1;
        bus1.req_trunc = 1'b0;
        bus1.req_wdata = 8'h5D;
        bus1.req_valid = 1'b1;
        do1 = 8'h11;
        chk("d1_ready_c0", 32'(bus1.req_ready), 32'd1);
        for (int k = 1; k <= LAT1 + 1; k++) begin
            @(posedge clk);
            #1;
            bus1.req_valid = 1'b0;
            do1 = (k == PRE1 + ACC1 + 1) ? 8'h6E : 8'h11;
            @(negedge clk);
            chk($sformatf("d1_ctl c%0d", k), 32'(ctl1), 32'(ctl_exp(k, PRE1, ACC1, 1'b0)));
            chk($sformatf("d1_latched c%0d", k), 32'(lat1), 32'({2'd3, 2'd2, 1'b1, 1'b0, 8'h5D}));
            chk($sformatf("d1_rdata c%0d", k), 32'(bus1.rsp_rdata), (k >= LAT1) ? 32'h6E : 32'h00);
        end

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
